fnd_page_scheduler: RTL and testbench
=====================================

Name: fnd_page_scheduler

Overview:
- Sequences which of the 7 SPI slave registers (pages 0..6) drives the 4-digit FND.
- Drives the one-hot page select consumed by the FND page mux: bit i selects slv_reg i.
- Three modes:
  - auto-scan of enabled pages;
  - manual page pick from debounced switches;
  - temporary preemption to a page that was just written over SPI.

Parameters:
- DWELL_CYCLES, 100_000_000: cycles each page is shown in AUTO.
- HOLD_CYCLES, 200_000_000: cycles a freshly written page is shown in PREEMPT.
- DEBOUNCE_CYCLES, 1_000_000: cycles the raw sw value must be stable before it is accepted.
- BLINK_CYCLES, 25_000_000: blank half-period in PREEMPT; used only with BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw  in  7  raw slide switches; one-hot selects a page.
- page_en  in  7  auto-scan inclusion mask; bit i = page i.
- wr_valid  in  1  one-cycle pulse: a slave register was written.
- wr_addr  in  3  index of the written register, 0..6; value 7 is ignored.
- sel  out  7  one-hot page select to the FND mux.
- page_idx  out  3  binary index of the current page.
- mode  out  2  0=AUTO, 1=MANUAL, 2=PREEMPT.
- blank  out  1  request to blank the FND.

Behaviour:
- Reset (synchronous, clk edge with reset=1) gives:
  - page_idx=0, sel=7'b0000001, mode=AUTO, blank=0;
  - sw_stable=0;
  - all counters 0, including the dwell, hold, debounce and blink counters.
- All outputs are registered. sel always equals 1<<page_idx, and both update on the same edge. Latency from a triggering event to the output change is 1 cycle.
- Debounce:
  - Any change of raw sw clears the debounce counter.
  - sw_stable takes the raw sw value after DEBOUNCE_CYCLES consecutive unchanged cycles.
- Mode decode from sw_stable, applied only when not in PREEMPT:
  - all zero -> AUTO;
  - exactly one bit set -> MANUAL, page_idx = index of that bit;
  - more than one bit set -> MANUAL with page_idx held at its current value and blank=1.
- AUTO:
  - The dwell counter runs 0..DWELL_CYCLES-1. On expiry, page_idx advances to the next enabled page in increasing index order, wrapping 6->0. The next-enabled search is combinational over all 7 candidates.
  - If the only enabled page is the current one, it stays.
  - If the current page is disabled, it is still shown until the next expiry.
  - If page_en==0: page_idx holds and blank=1.
  - Entering AUTO from another mode keeps page_idx and clears the dwell counter.
- PREEMPT:
  - Entered from any mode on wr_valid=1 with wr_addr<=6. page_idx=wr_addr and the hold counter is cleared.
  - Another valid write while in PREEMPT retargets the page and restarts the hold.
  - After HOLD_CYCLES cycles, the block leaves PREEMPT according to the mode decode of the sw_stable value at that moment. The dwell counter restarts from 0.
  - sw_stable changes during PREEMPT are recorded but not acted on until exit.
- Simultaneous events:
  - A valid write beats dwell expiry and beats a sw_stable change in the same cycle.
  - wr_valid with wr_addr=7 has no effect, including no hold restart.
- Reset asserted mid-operation, in any mode, returns all state to reset values on that edge.

Optional Feature:
- Macro: FND_SCHED_BLINK_EN.
- Defined: in PREEMPT, blank starts at 0 on entry and toggles every BLINK_CYCLES. It is forced to 0 on exit unless AUTO/MANUAL blank rules apply.
- Undefined: blank=0 throughout PREEMPT, and no blink counter is built.

Decomposition:
- Package fnd_sched_pkg holds:
  - NUM_PAGES=7 and PAGE_W=3;
  - mode encoding constants MODE_AUTO=0, MODE_MANUAL=1, MODE_PREEMPT=2.
- One sub-module: fnd_sw_debounce.
  - Parameter DEBOUNCE_CYCLES; ports clk, reset, sw_raw[6:0], sw_stable[6:0].
- Mode FSM, dwell/hold/blink counters and next-enabled search stay in fnd_page_scheduler.

Test Plan (DWELL=4, HOLD=8, DEBOUNCE=3, BLINK=2):
- Reset, sw=0, page_en=7'h7F -> sel walks 0x01,0x02,...,0x40,0x01, each value held 4 cycles; mode=0.
- page_en=7'b0010010, start on page 1 -> page_idx 1,4,1,4 every 4 cycles. Then page_en=0 -> page_idx holds, blank=1.
- sw=7'b0000100 held 3+ cycles -> mode=1, sel=0x04. A 2-cycle glitch to 7'b0001000 -> no change. sw=7'b0000011 -> blank=1, page held.
- In AUTO on page 1, wr_valid with wr_addr=5 -> next cycle sel=0x20, mode=2. A second write of addr 2 after 5 cycles -> sel=0x04, hold restarts. After 8 further cycles -> mode=0; page 2 holds 4 cycles, then page 3.
- wr_valid with addr 6 coincident with dwell expiry -> sel=0x40 (preempt wins). wr_valid with wr_addr=7 -> no change.
- With FND_SCHED_BLINK_EN defined -> blank toggles 0,0,1,1,... during hold. reset=1 mid-PREEMPT -> next edge sel=0x01, mode=0, blank=0.

Source files
------------

// File: rtl/fnd_sched_pkg.sv
// rtl/fnd_sched_pkg.sv - shared sizes, mode encoding and helpers for the FND page scheduler
package fnd_sched_pkg;
  localparam int NUM_PAGES = 7;
  localparam int PAGE_W    = 3;

  typedef enum logic [1:0] {
    MODE_AUTO    = 2'd0,
    MODE_MANUAL  = 2'd1,
    MODE_PREEMPT = 2'd2
  } mode_e;

  // Index of the lowest set bit; only meaningful for a one-hot input.
  function automatic logic [PAGE_W-1:0] lowest_bit_idx(input logic [NUM_PAGES-1:0] v);
    lowest_bit_idx = '0;
    for (int i = NUM_PAGES - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit_idx = PAGE_W'(i);
    end
  endfunction
endpackage

// File: rtl/fnd_sw_debounce.sv
// rtl/fnd_sw_debounce.sv - accepts the raw switch vector once it has been stable long enough
module fnd_sw_debounce
  import fnd_sched_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PAGES-1:0] sw_raw,
  output logic [NUM_PAGES-1:0] sw_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_PAGES-1:0] r_sw_last;
  logic [NUM_PAGES-1:0] r_sw_stable;
  logic [CW-1:0]        r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_last   <= '0;
      r_sw_stable <= '0;
      r_cnt       <= '0;
    end else if (sw_raw != r_sw_last) begin
      r_sw_last <= sw_raw;
      r_cnt     <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_sw_stable <= r_sw_last;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign sw_stable = r_sw_stable;
endmodule

// File: rtl/fnd_page_scheduler.sv
// rtl/fnd_page_scheduler.sv - picks the slave register page shown on the FND (auto/manual/preempt)
// Optional PREEMPT blinking is built when FND_SCHED_BLINK_EN is defined.
module fnd_page_scheduler
  import fnd_sched_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 100_000_000,
  parameter int unsigned HOLD_CYCLES     = 200_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PAGES-1:0] sw,
  input  logic [NUM_PAGES-1:0] page_en,
  input  logic                 wr_valid,
  input  logic [PAGE_W-1:0]    wr_addr,
  output logic [NUM_PAGES-1:0] sel,
  output logic [PAGE_W-1:0]    page_idx,
  output logic [1:0]           mode,
  output logic                 blank
);
  localparam int DWW = $clog2(DWELL_CYCLES + 1);
  localparam int HW  = $clog2(HOLD_CYCLES + 1);

  mode_e                r_mode, w_mode_nx, w_dec_mode;
  logic [PAGE_W-1:0]    r_page, w_page_nx, w_dec_page, w_next_en, w_sw_idx;
  logic [NUM_PAGES-1:0] r_sel, w_sw_stable;
  logic                 r_blank, w_blank_nx, w_dec_blank, w_wr_hit;
  logic [DWW-1:0]       r_dwell, w_dwell_nx;
  logic [HW-1:0]        r_hold, w_hold_nx;
  logic [PAGE_W:0]      w_cand;

  fnd_sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw),
    .sw_stable (w_sw_stable)
  );

  assign w_wr_hit = wr_valid && (wr_addr != PAGE_W'(NUM_PAGES));
  assign w_sw_idx = lowest_bit_idx(w_sw_stable);

  // Nearest enabled page after the current one, wrapping; k=NUM_PAGES lands back on itself.
  always_comb begin
    w_next_en = r_page;
    w_cand    = '0;
    for (int k = NUM_PAGES; k >= 1; k--) begin
      w_cand = {1'b0, r_page} + (PAGE_W + 1)'(k);
      if (w_cand >= (PAGE_W + 1)'(NUM_PAGES)) w_cand = w_cand - (PAGE_W + 1)'(NUM_PAGES);
      if (page_en[w_cand[PAGE_W-1:0]]) w_next_en = w_cand[PAGE_W-1:0];
    end
  end

  always_comb begin
    w_dec_mode  = MODE_MANUAL;
    w_dec_page  = r_page;
    w_dec_blank = 1'b1;
    if (w_sw_stable == '0) begin
      w_dec_mode  = MODE_AUTO;
      w_dec_blank = (page_en == '0);
    end else if ($onehot(w_sw_stable)) begin
      w_dec_page  = w_sw_idx;
      w_dec_blank = 1'b0;
    end
  end

`ifdef FND_SCHED_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] r_blink, w_blink_nx;

  always_ff @(posedge clk) begin
    if (reset) r_blink <= '0;
    else       r_blink <= w_blink_nx;
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^BLINK_CYCLES;
`endif

  always_comb begin
    w_mode_nx  = r_mode;
    w_page_nx  = r_page;
    w_blank_nx = r_blank;
    w_dwell_nx = r_dwell;
    w_hold_nx  = r_hold;
`ifdef FND_SCHED_BLINK_EN
    w_blink_nx = r_blink;
`endif
    if (w_wr_hit) begin
      w_mode_nx  = MODE_PREEMPT;
      w_page_nx  = wr_addr;
      w_blank_nx = 1'b0;
      w_dwell_nx = '0;
      w_hold_nx  = '0;
`ifdef FND_SCHED_BLINK_EN
      w_blink_nx = '0;
`endif
    end else if (r_mode == MODE_PREEMPT) begin
      if (r_hold == HW'(HOLD_CYCLES - 1)) begin
        w_mode_nx  = w_dec_mode;
        w_page_nx  = w_dec_page;
        w_blank_nx = w_dec_blank;
        w_dwell_nx = '0;
        w_hold_nx  = '0;
      end else begin
        w_hold_nx = r_hold + HW'(1);
`ifdef FND_SCHED_BLINK_EN
        if (r_blink == BW'(BLINK_CYCLES - 1)) begin
          w_blink_nx = '0;
          w_blank_nx = ~r_blank;
        end else begin
          w_blink_nx = r_blink + BW'(1);
        end
`endif
      end
    end else begin
      w_mode_nx  = w_dec_mode;
      w_page_nx  = w_dec_page;
      w_blank_nx = w_dec_blank;
      w_dwell_nx = '0;
      // Dwell only accumulates while already in AUTO; entering AUTO starts it at 0.
      if (w_dec_mode == MODE_AUTO && r_mode == MODE_AUTO) begin
        if (r_dwell == DWW'(DWELL_CYCLES - 1)) w_page_nx = w_next_en;
        else                                   w_dwell_nx = r_dwell + DWW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= MODE_AUTO;
      r_page  <= '0;
      r_sel   <= NUM_PAGES'(1);
      r_blank <= 1'b0;
      r_dwell <= '0;
      r_hold  <= '0;
    end else begin
      r_mode  <= w_mode_nx;
      r_page  <= w_page_nx;
      r_sel   <= NUM_PAGES'(1) << w_page_nx;
      r_blank <= w_blank_nx;
      r_dwell <= w_dwell_nx;
      r_hold  <= w_hold_nx;
    end
  end

  assign sel      = r_sel;
  assign page_idx = r_page;
  assign mode     = r_mode;
  assign blank    = r_blank;
endmodule

// File: tb/tb_fnd_page_scheduler.sv
// tb/tb_fnd_page_scheduler.sv - directed scoreboard bench for fnd_page_scheduler (DWELL=4 HOLD=8 DEBOUNCE=3 BLINK=2)
module tb_fnd_page_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] sw, page_en, sel;
  logic       wr_valid, blank;
  logic [2:0] wr_addr, page_idx;
  logic [1:0] mode;

  typedef struct packed {
    logic [2:0] idx;
    logic [1:0] md;
    logic       bl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  fnd_page_scheduler #(
    .DWELL_CYCLES(4), .HOLD_CYCLES(8), .DEBOUNCE_CYCLES(3), .BLINK_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .page_en(page_en), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .sel(sel), .page_idx(page_idx), .mode(mode), .blank(blank)
  );

  always #5 clk = ~clk;

  function automatic logic bl(input int n);
`ifdef FND_SCHED_BLINK_EN
    return 1'((n / 2) % 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input int idx, input int md, input logic b);
    exp_t e;
    logic [6:0] esel;
    e.idx = 3'(idx);
    e.md  = 2'(md);
    e.bl  = b;
    q.push_back(e);
    @(posedge clk);
    #1;
    e    = q.pop_front();
    esel = 7'(1 << e.idx);
    checks++;
    assert ({sel, page_idx, mode, blank} === {esel, e.idx, e.md, e.bl})
    else begin
      errors++;
      $error("FAIL %s: got sel=%h idx=%0d mode=%0d blank=%b, expected sel=%h idx=%0d mode=%0d blank=%b",
             tag, sel, page_idx, mode, blank, esel, e.idx, e.md, e.bl);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sw = '0; page_en = 7'h7F; wr_valid = 1'b0; wr_addr = '0;
    #1;
    chk("reset", 0, 0, 0);
    reset = 1'b0;

    // Full auto walk 0..6 then wrap to 0
    repeat (3) chk("walk0", 0, 0, 0);
    for (int p = 1; p < 7; p++) repeat (4) chk("walk", p, 0, 0);
    repeat (4) chk("wrap0", 0, 0, 0);

    page_en = 7'b0010010;
    for (int r = 0; r < 2; r++) begin
      repeat (4) chk("en_1", 1, 0, 0);
      repeat (4) chk("en_4", 4, 0, 0);
    end
    page_en = '0;
    repeat (6) chk("no_en", 4, 0, 1);

    reset = 1'b1; page_en = 7'h7F;
    chk("reset2", 0, 0, 0);
    reset = 1'b0; sw = 7'b0000100;
    idle(6);
    repeat (3) chk("manual", 2, 1, 0);
    sw = 7'b0001000;
    repeat (2) chk("glitch", 2, 1, 0);
    sw = 7'b0000100;
    repeat (6) chk("post_glitch", 2, 1, 0);
    sw = 7'b0000011;
    idle(6);
    repeat (3) chk("multi", 2, 1, 1);

    reset = 1'b1; sw = '0;
    chk("reset3", 0, 0, 0);
    reset = 1'b0;
    repeat (3) chk("auto0", 0, 0, 0);
    repeat (2) chk("auto1", 1, 0, 0);
    wr_valid = 1'b1; wr_addr = 3'd5;
    chk("preempt", 5, 2, bl(0));
    wr_valid = 1'b0;
    for (int n = 1; n <= 4; n++) chk("hold5", 5, 2, bl(n));
    wr_valid = 1'b1; wr_addr = 3'd2;
    chk("retarget", 2, 2, bl(0));
    wr_valid = 1'b0;
    for (int n = 1; n <= 7; n++) chk("hold2", 2, 2, bl(n));
    repeat (4) chk("exit", 2, 0, 0);
    repeat (4) chk("after", 3, 0, 0);

    wr_valid = 1'b1; wr_addr = 3'd6;
    chk("coincide", 6, 2, bl(0));
    wr_valid = 1'b0;
    for (int n = 1; n <= 3; n++) chk("hold6", 6, 2, bl(n));
    wr_valid = 1'b1; wr_addr = 3'd7;
    chk("addr7_pre", 6, 2, bl(4));
    wr_valid = 1'b0;
    for (int n = 5; n <= 7; n++) chk("hold6b", 6, 2, bl(n));
    chk("hold_end", 6, 0, 0);
    wr_valid = 1'b1; wr_addr = 3'd7;
    chk("addr7_auto", 6, 0, 0);
    wr_valid = 1'b0;
    repeat (2) chk("auto6", 6, 0, 0);
    chk("wrap6", 0, 0, 0);

    wr_valid = 1'b1; wr_addr = 3'd3;
    chk("pre3", 3, 2, bl(0));
    wr_valid = 1'b0;
    chk("pre3", 3, 2, bl(1));
    chk("pre3", 3, 2, bl(2));
    reset = 1'b1;
    chk("mid_reset", 0, 0, 0);
    reset = 1'b0;
    repeat (3) chk("post_reset", 0, 0, 0);
    chk("post_reset1", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
